uart_rx_frame_parser: RTL and testbench

- Sits directly downstream of the UART byte receiver.
- Consumes the receiver's one-cycle done pulse and byte, then locates framed packets, packs payload bytes into DATA_W-bit words and checks an XOR checksum.
- Delivers words through a small first-word-fall-through FIFO with valid/ready handshake to the softmax datapath, and reports per-frame status.

---
 rtl/uart_rx_frame_parser.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART byte receiver: finds SYNC/LEN/payload/CHK frames,
// packs payload bytes little-endian into words and streams them through a small FWFT FIFO.
module uart_rx_frame_parser #(
  parameter int          DATA_W      = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_done,
  input  logic [7:0]        i_rxd,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word,
  input  logic              i_word_ready,
  output logic              o_frame_done,
  output logic [2:0]        o_err_code,
  output logic              o_busy
);

  // state   | meaning
  // IDLE    | hunting for SYNC_BYTE
  // LEN     | waiting for word count
  // PAYLOAD | collecting payload bytes, pushing completed words
  // CHK     | waiting for checksum byte
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                done_q, done_d;
  logic [2:0]          err_q, err_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      fcnt_q, fcnt_d;

  logic                tmo, last_byte, push_req, push_ok, pop;
  logic [DATA_W-1:0]   asm_word;

  assign tmo       = (state_q != S_IDLE) && !i_rx_done && (tmr_q == TMR_LAST);
  assign last_byte = (idx_q == IDX_W'(BYTES - 1));
  assign pop       = (fcnt_q != '0) && i_word_ready;
  assign push_ok   = push_req && ((fcnt_q != DEPTH_C) || pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = S_IDLE;
    end else if (i_rx_done) begin
      case (state_q)
        S_IDLE:    if (i_rxd == SYNC_BYTE) state_d = S_LEN;
        S_LEN:     state_d = (i_rxd == 8'd0) ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: if (last_byte && (cnt_q == 8'd1)) state_d = S_CHK;
        S_CHK:     state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    word_d   = word_q;
    done_d   = 1'b0;
    err_d    = 3'd0;
    push_req = 1'b0;
    tmr_d    = (state_q == S_IDLE || i_rx_done) ? '0 : tmr_q + TMR_W'(1);
    asm_word = word_q;
    for (int b = 0; b < BYTES; b++)
      if (idx_q == IDX_W'(b)) asm_word[b*8 +: 8] = i_rxd;

    if (tmo) begin
      done_d = 1'b1;
      err_d  = 3'd4;
      word_d = '0;
      idx_d  = '0;
      tmr_d  = '0;
    end else if (i_rx_done) begin
      case (state_q)
        S_LEN: begin
          if (i_rxd == 8'd0) begin
            done_d = 1'b1;
            err_d  = 3'd1;
          end else begin
            cnt_d  = i_rxd;
            acc_d  = i_rxd;
            idx_d  = '0;
            ovf_d  = 1'b0;
            word_d = '0;
          end
        end
        S_PAYLOAD: begin
          acc_d = acc_q ^ i_rxd;
          if (last_byte) begin
            push_req = 1'b1;
            cnt_d    = cnt_q - 8'd1;
            idx_d    = '0;
            word_d   = '0;
          end else begin
            word_d = asm_word;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
        S_CHK: begin
          done_d = 1'b1;
          if (ovf_q)               err_d = 3'd3;
          else if (i_rxd != acc_q) err_d = 3'd2;
          else                     err_d = 3'd0;
        end
        default: ;
      endcase
    end
    // a word that finds the FIFO full (with no pop this cycle) is lost
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = asm_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + (PTR_W + 1)'(1);
      2'b01:   fcnt_d = fcnt_q - (PTR_W + 1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      word_q   <= '0;
      tmr_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      word_q   <= word_d;
      tmr_q    <= tmr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      mem_q    <= mem_d;
    end
  end

  assign o_word_valid = (fcnt_q != '0);
  assign o_word       = mem_q[rd_ptr_q];
  assign o_frame_done = done_q;
  assign o_err_code   = err_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: frame table plus overflow, timeout and reset sequences.
module tb_uart_rx_frame_parser;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rxd;
  logic        word_valid;
  logic [15:0] word;
  logic        word_ready;
  logic        frame_done;
  logic [2:0]  err_code;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_q[$];
  int          done_cnt;
  logic [2:0]  last_err;

  uart_rx_frame_parser #(
    .DATA_W(16), .SYNC_BYTE(8'hA5), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_done(rx_done), .i_rxd(rxd),
    .o_word_valid(word_valid), .o_word(word), .i_word_ready(word_ready),
    .o_frame_done(frame_done), .o_err_code(err_code), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // words popped and frame-end pulses, observed mid-cycle
  always @(negedge clk) begin
    if (word_valid && word_ready) got_q.push_back(word);
    if (frame_done) begin
      done_cnt++;
      last_err = err_code;
    end
  end

  typedef struct {
    logic [0:7][7:0] bytes;
    int              nb;
    logic [15:0]     w0;
    logic [15:0]     w1;
    int              nw;
    logic [2:0]      err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rxd     = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    last_err = 3'd0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    clear_mon();
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[i]);
    check($sformatf("v%0d done_pulse", id), frame_done, 1'b1);
    check($sformatf("v%0d err_code", id), err_code, v.err);
    @(posedge clk); #1;
    check($sformatf("v%0d done_drop", id), frame_done, 1'b0);
    check($sformatf("v%0d err_clear", id), err_code, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("v%0d nwords", id), got_q.size(), v.nw);
    if (v.nw > 0 && got_q.size() > 0) check($sformatf("v%0d word0", id), got_q[0], v.w0);
    if (v.nw > 1 && got_q.size() > 1) check($sformatf("v%0d word1", id), got_q[1], v.w1);
    check($sformatf("v%0d done_cnt", id), done_cnt, 1);
    check($sformatf("v%0d busy", id), busy, 1'b0);
    check($sformatf("v%0d valid", id), word_valid, 1'b0);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{bytes: {8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 8'h00}, nb: 7,
                w0: 16'h1234, w1: 16'h5678, nw: 2, err: 3'd0};
    vecs[1] = '{bytes: {8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B, 8'h00}, nb: 7,
                w0: 16'h1234, w1: 16'h5678, nw: 2, err: 3'd2};
    vecs[2] = '{bytes: {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 4,
                w0: 16'h0000, w1: 16'h0000, nw: 0, err: 3'd1};
    vecs[3] = '{bytes: {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00}, nb: 5,
                w0: 16'hA5A5, w1: 16'h0000, nw: 1, err: 3'd0};
    vecs[4] = '{bytes: {8'h33, 8'hA5, 8'h01, 8'hCD, 8'hAB, 8'h67, 8'h00, 8'h00}, nb: 6,
                w0: 16'hABCD, w1: 16'h0000, nw: 1, err: 3'd0};

    rst = 1'b1; rx_done = 1'b0; rxd = 8'h00; word_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", word_valid, 1'b0);
    check("rst word", word, 16'h0000);
    check("rst done", frame_done, 1'b0);
    check("rst err", err_code, 3'd0);
    check("rst busy", busy, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // valid rises right after the byte completing a word
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hEF);
    check("lat valid_before", word_valid, 1'b0);
    check("lat busy", busy, 1'b1);
    send_byte(8'hBE);
    check("lat valid_after", word_valid, 1'b1);
    check("lat word", word, 16'hBEEF);
    send_byte(8'h01 ^ 8'hEF ^ 8'hBE);
    check("lat err", err_code, 3'd0);

    // overflow: 5 words into a 4-deep FIFO with the consumer stalled
    word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h05);
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    send_byte(8'h0E);
    check("ovf done", frame_done, 1'b1);
    check("ovf err", err_code, 3'd3);
    check("ovf valid", word_valid, 1'b1);
    check("ovf head", word, 16'h0201);
    check("ovf none_popped", got_q.size(), 0);
    word_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("ovf drain_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("ovf drain%0d", i), got_q[i], {8'(2*i + 2), 8'(2*i + 1)});
    check("ovf empty", word_valid, 1'b0);

    // timeout mid-payload
    clear_mon();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34);
    repeat (TMO - 3) @(posedge clk);
    #1;
    check("tmo early_busy", busy, 1'b1);
    check("tmo early_done", done_cnt, 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (frame_done) seen = 1'b1;
    end
    check("tmo seen", seen, 1'b1);
    check("tmo err", err_code, 3'd4);
    repeat (TMO + 5) @(posedge clk);
    #1;
    check("tmo once", done_cnt, 1);
    check("tmo busy", busy, 1'b0);
    check("tmo empty", word_valid, 1'b0);
    check("tmo nwords", got_q.size(), 0);
    run_vec(vecs[0], 10);

    // reset mid-payload with two words queued
    word_ready = 1'b0;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h03);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("mid valid", word_valid, 1'b1);
    check("mid busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst valid", word_valid, 1'b0);
    check("arst busy", busy, 1'b0);
    check("arst word", word, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    word_ready = 1'b1;
    check("arst no_done", done_cnt, 0);
    run_vec(vecs[0], 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
